// File: rtl/mvu_seq_pkg.sv
// Shared types for the MVU job sequencer: FSM states, delay-line entry, job descriptor.
package mvu_seq_pkg;

    localparam int unsigned SEQ_BWBANKA = 9;
    localparam int unsigned SEQ_BDBANKA = 14;
    localparam int unsigned SEQ_BPREC   = 4;
    localparam int unsigned SEQ_BTILE   = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLR,
        ST_RUN,
        ST_FLUSH
    } seq_state_e;

    // One accumulator-control slot travelling alongside a read.
    typedef struct packed {
        logic                 clr;
        logic                 acc;
        logic                 sh;
        logic                 neg;
        logic                 last;
        logic [SEQ_BTILE-1:0] tile;
    } ctrl_entry_t;

    typedef struct packed {
        logic [SEQ_BPREC-1:0]   iprec;
        logic [SEQ_BPREC-1:0]   wprec;
        logic                   isign;
        logic                   wsign;
        logic [SEQ_BTILE-1:0]   ktiles;
        logic [SEQ_BTILE-1:0]   otiles;
        logic [SEQ_BDBANKA-1:0] dbase;
        logic [SEQ_BWBANKA-1:0] wbase;
    } seq_desc_t;

endpackage

// File: rtl/mvu_ctrl_delay.sv
// RDLAT-stage pipeline aligning accumulator controls with bank read data.
module mvu_ctrl_delay
    import mvu_seq_pkg::*;
#(
    parameter int unsigned RDLAT = 2
) (
    input  logic        clk,
    input  logic        flush,
    input  ctrl_entry_t in_entry,
    output ctrl_entry_t out_entry,
    output logic        live
);

    ctrl_entry_t stage_q [RDLAT];
    ctrl_entry_t stage_d [RDLAT];

    // Shift one stage per cycle; report whether any real slot is still in flight.
    always_comb begin
        stage_d[0] = in_entry;
        for (int unsigned i = 1; i < RDLAT; i++) begin
            stage_d[i] = stage_q[i-1];
        end
        live = 1'b0;
        for (int unsigned i = 0; i < RDLAT; i++) begin
            live = live | stage_q[i].clr | stage_q[i].acc;
        end
    end

    // Stage registers with synchronous flush.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < RDLAT; i++) begin
            if (flush) begin
                stage_q[i] <= '0;
            end else begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign out_entry = stage_q[RDLAT-1];

endmodule

// File: rtl/mvu_job_seq.sv
// Job sequencer: walks bit-plane diagonals per output tile, issuing bank reads and
// pipelined shift-accumulate controls, then pulses done.
module mvu_job_seq
    import mvu_seq_pkg::*;
#(
    parameter int unsigned BWBANKA = SEQ_BWBANKA,
    parameter int unsigned BDBANKA = SEQ_BDBANKA,
    parameter int unsigned BPREC   = SEQ_BPREC,
    parameter int unsigned BTILE   = SEQ_BTILE,
    parameter int unsigned RDLAT   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [BPREC-1:0]   cfg_iprec,
    input  logic [BPREC-1:0]   cfg_wprec,
    input  logic               cfg_isign,
    input  logic               cfg_wsign,
    input  logic [BTILE-1:0]   cfg_ktiles,
    input  logic [BTILE-1:0]   cfg_otiles,
    input  logic [BDBANKA-1:0] cfg_dbase,
    input  logic [BWBANKA-1:0] cfg_wbase,
    output logic               busy,
    output logic               done,
    output logic [BWBANKA-1:0] rdw_addr,
    output logic               rdd_en,
    input  logic               rdd_grnt,
    output logic [BDBANKA-1:0] rdd_addr,
    output logic               shacc_clr,
    output logic               shacc_acc,
    output logic               shacc_sh,
    output logic               neg_acc,
    output logic               tile_valid,
    output logic [BTILE-1:0]   tile_idx
);

    localparam int unsigned SW = BPREC + 1;

    seq_state_e       state_q, state_d;
    seq_desc_t        desc_q, desc_d;
    logic [BTILE-1:0] t_q, t_d, k_q, k_d;
    logic [SW-1:0]    s_q, s_d;
    logic [BPREC-1:0] ww_q, ww_d;

    logic [SW-1:0] s_top, s_prev, wp_m1, ww_hi, ww_lo, ww_hi_prev, ii;
    logic          first_of_diag, last_k, zero_job;
    ctrl_entry_t   dl_in, dl_out;
    logic          dl_live;

    function automatic logic [SW-1:0] diag_top(input logic [BPREC-1:0] ip, input logic [BPREC-1:0] wp);
        return SW'(ip) + SW'(wp) - SW'(2);
    endfunction

    // Diagonal bounds and read addresses for the current issue position.
    always_comb begin
        s_top         = diag_top(desc_q.iprec, desc_q.wprec);
        wp_m1         = SW'(desc_q.wprec) - SW'(1);
        ww_hi         = (s_q < wp_m1) ? s_q : wp_m1;
        ww_lo         = (s_q + SW'(1) > SW'(desc_q.iprec)) ? s_q + SW'(1) - SW'(desc_q.iprec) : '0;
        s_prev        = s_q - SW'(1);
        ww_hi_prev    = (s_prev < wp_m1) ? s_prev : wp_m1;
        ii            = s_q - SW'(ww_q);
        first_of_diag = (k_q == '0) && (SW'(ww_q) == ww_hi);
        last_k        = (k_q == desc_q.ktiles - BTILE'(1));
        zero_job      = (cfg_iprec == '0) || (cfg_wprec == '0) || (cfg_ktiles == '0) || (cfg_otiles == '0);
        rdd_addr      = '0;
        rdw_addr      = '0;
        if (state_q == ST_RUN) begin
            rdd_addr = BDBANKA'(32'(desc_q.dbase) + 32'(k_q) * 32'(desc_q.iprec) + 32'(ii));
            rdw_addr = BWBANKA'(32'(desc_q.wbase)
                                + (32'(t_q) * 32'(desc_q.ktiles) + 32'(k_q)) * 32'(desc_q.wprec)
                                + 32'(ww_q));
        end
    end

    // Next-state, counter advance and delay-line injection.
    always_comb begin
        state_d   = state_q;
        desc_d    = desc_q;
        t_d       = t_q;
        k_d       = k_q;
        s_d       = s_q;
        ww_d      = ww_q;
        dl_in     = '0;
        cfg_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        rdd_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid && !rst) begin
                    busy   = 1'b1;
                    desc_d = '{iprec: cfg_iprec, wprec: cfg_wprec, isign: cfg_isign, wsign: cfg_wsign,
                               ktiles: cfg_ktiles, otiles: cfg_otiles, dbase: cfg_dbase, wbase: cfg_wbase};
                    t_d     = '0;
                    k_d     = '0;
                    s_d     = diag_top(cfg_iprec, cfg_wprec);
                    ww_d    = cfg_wprec - BPREC'(1);
                    state_d = zero_job ? ST_FLUSH : ST_CLR;
                end
            end
            ST_CLR: begin
                busy       = 1'b1;
                dl_in.clr  = 1'b1;
                dl_in.tile = t_q;
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                busy   = 1'b1;
                rdd_en = 1'b1;
                if (rdd_grnt) begin
                    dl_in.acc  = 1'b1;
                    dl_in.sh   = first_of_diag && (s_q != s_top);
                    dl_in.neg  = (desc_q.isign && (ii == SW'(desc_q.iprec) - SW'(1)))
                               ^ (desc_q.wsign && (ww_q == desc_q.wprec - BPREC'(1)));
                    dl_in.last = (s_q == '0) && last_k;
                    dl_in.tile = t_q;
                    // k innermost, then ww down the diagonal, then next diagonal, then next tile
                    if (!last_k) begin
                        k_d = k_q + BTILE'(1);
                    end else begin
                        k_d = '0;
                        if (SW'(ww_q) > ww_lo) begin
                            ww_d = ww_q - BPREC'(1);
                        end else if (s_q != '0) begin
                            s_d  = s_prev;
                            ww_d = BPREC'(ww_hi_prev);
                        end else begin
                            t_d     = t_q + BTILE'(1);
                            s_d     = s_top;
                            ww_d    = desc_q.wprec - BPREC'(1);
                            state_d = (t_q == desc_q.otiles - BTILE'(1)) ? ST_FLUSH : ST_CLR;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                busy = 1'b1;
                if (!dl_live) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            desc_q  <= '0;
            t_q     <= '0;
            k_q     <= '0;
            s_q     <= '0;
            ww_q    <= '0;
        end else begin
            state_q <= state_d;
            desc_q  <= desc_d;
            t_q     <= t_d;
            k_q     <= k_d;
            s_q     <= s_d;
            ww_q    <= ww_d;
        end
    end

    mvu_ctrl_delay #(.RDLAT(RDLAT)) u_delay (
        .clk       (clk),
        .flush     (rst),
        .in_entry  (dl_in),
        .out_entry (dl_out),
        .live      (dl_live)
    );

    assign shacc_clr  = dl_out.clr;
    assign shacc_acc  = dl_out.acc;
    assign shacc_sh   = dl_out.sh;
    assign neg_acc    = dl_out.neg;
    assign tile_valid = dl_out.last;
    assign tile_idx   = dl_out.last ? dl_out.tile : '0;

endmodule
